// File: rtl/mem_loader_if.sv
// mem_loader_if: byte-stream input, memory port and status bundle for the loader
interface mem_loader_if;
  logic        start;
  logic [15:0] n_words;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_reset;
  modport master (
    input  start, n_words, in_data, in_valid, ReadData,
    output in_ready, MemWrite, Adr, WriteData, busy, done, err, cpu_reset
  );
  modport slave (
    output start, n_words, in_data, in_valid, ReadData,
    input  in_ready, MemWrite, Adr, WriteData, busy, done, err, cpu_reset
  );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: packs a byte stream into words, writes and reads back each one, then releases the core
module mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 64
) (
  input logic          clk,
  input logic          reset,
  mem_loader_if.master bus
);
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, VERIFY, DONE} state_t;
  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);
  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [15:0] n_q, n_d;
  logic        err_q, err_d;
  logic        xfer;
  logic [31:0] adr;
  assign xfer = state_q == WRITE || state_q == VERIFY;
  assign adr  = BASE_ADDR + {14'b0, word_idx_q, 2'b00};
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    n_d        = n_q;
    err_d      = err_q;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        n_d        = bus.n_words;
        word_idx_d = '0;
        byte_cnt_d = '0;
        err_d      = bus.n_words > MAX_N;
        state_d    = (bus.n_words == '0 || bus.n_words > MAX_N) ? DONE : COLLECT;
      end
      COLLECT: if (bus.in_valid) begin
        word_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
        byte_cnt_d = byte_cnt_q + 2'd1;
        state_d    = byte_cnt_q == 2'd3 ? WRITE : COLLECT;
      end
      WRITE: state_d = VERIFY;
      VERIFY: begin
        err_d      = err_q | (bus.ReadData != word_q);
        word_idx_d = word_idx_q + 16'd1;
        state_d    = (word_idx_q + 16'd1 == n_q) ? DONE : COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      word_q     <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      n_q        <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      n_q        <= n_d;
      err_q      <= err_d;
    end
  end
  assign bus.in_ready  = state_q == COLLECT;
  assign bus.MemWrite  = state_q == WRITE;
  assign bus.Adr       = xfer ? adr : '0;
  assign bus.WriteData = xfer ? word_q : '0;
  assign bus.busy      = state_q == COLLECT || xfer;
  assign bus.done      = state_q == DONE;
  assign bus.err       = err_q;
  assign bus.cpu_reset = state_q != DONE;
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: drives byte loads into mem_loader and checks the writes against a word-packing model
module tb_mem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_loader_if bus();
  mem_loader dut (.clk(clk), .reset(rst_n), .bus(bus));
  logic [31:0] mem [0:255];
  logic [31:0] wadr[$], wdat[$];
  logic [7:0]  bytes_q[$];
  bit fault;
  int errors, checks, cyc, wr_cyc, start_cyc, hs, viol;
  assign bus.ReadData = (fault && bus.Adr == 32'd4) ? 32'hFFFF_FFFF : mem[bus.Adr[9:2]];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.MemWrite) begin
      if (wadr.size() == 0) wr_cyc = cyc;
      wadr.push_back(bus.Adr);
      wdat.push_back(bus.WriteData);
      mem[bus.Adr[9:2]] = bus.WriteData;
    end
    if (bus.in_ready && (bus.MemWrite || bus.WriteData != 0 || !bus.busy)) viol++;
    if (!bus.busy && (bus.Adr != 0 || bus.WriteData != 0)) viol++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic gen(input int nb);
    bytes_q.delete();
    repeat (nb) bytes_q.push_back(8'($urandom));
  endtask
  // mode 0: valid held, 1: valid toggles, 2: random gaps, 3: held plus a stray start mid-load
  task automatic run_load(input int n, input int nb, input int mode);
    int idx = 0;
    int g = 0;
    wadr.delete();
    wdat.delete();
    hs = 0;
    wr_cyc = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n_words = 16'(n);
    start_cyc = cyc;
    while (idx < nb && g < 4000) begin
      bus.in_valid = mode == 1 ? g[0] : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data = bytes_q[idx];
      if (mode == 3 && idx == 5) begin
        bus.start = 1'b1;
        bus.n_words = 16'd5;
      end
      #1;
      if (bus.in_valid && bus.in_ready) begin
        idx++;
        hs++;
      end
      @(negedge clk);
      bus.start = 1'b0;
      g++;
    end
    if (g == 0) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("bytes_fed", idx, nb);
  endtask
  task automatic wait_done();
    int k = 0;
    while (!bus.done && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", bus.done, 1);
  endtask
  task automatic check_writes(input int n);
    chk("n_writes", wadr.size(), n);
    for (int i = 0; i < n && i < wadr.size(); i++) begin
      chk($sformatf("adr%0d", i), wadr[i], 32'(4 * i));
      chk($sformatf("data%0d", i), wdat[i],
          {bytes_q[4*i+3], bytes_q[4*i+2], bytes_q[4*i+1], bytes_q[4*i]});
    end
  endtask
  task automatic check_reset_outs(input string tag);
    chk({tag, "_flags"}, {bus.in_ready, bus.MemWrite, bus.busy, bus.done, bus.err, bus.cpu_reset}, 6'b000001);
    chk({tag, "_adr"}, bus.Adr, 0);
    chk({tag, "_wdata"}, bus.WriteData, 0);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.n_words = '0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    fault = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    // basic load, valid held
    bytes_q = {8'h07, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'hDE};
    run_load(2, 8, 0);
    wait_done();
    check_writes(2);
    chk("first_write_latency", wr_cyc - start_cyc, 5);
    chk("basic_status", {bus.err, bus.cpu_reset, bus.busy}, 3'b000);
    // toggling valid
    run_load(2, 8, 1);
    wait_done();
    check_writes(2);
    chk("handshakes", hs, 8);
    // readback fault at word 1
    fault = 1'b1;
    run_load(2, 8, 0);
    wait_done();
    check_writes(2);
    chk("fault_err", bus.err, 1);
    fault = 1'b0;
    // bad counts
    pulse_reset();
    run_load(0, 0, 0);
    chk("n0_done", bus.done, 1);
    chk("n0_err", bus.err, 0);
    chk("n0_writes", wadr.size(), 0);
    run_load(65, 0, 0);
    chk("n65_done", bus.done, 1);
    chk("n65_err", bus.err, 1);
    chk("n65_writes", wadr.size(), 0);
    // reset mid-load after 6 bytes
    gen(8);
    run_load(2, 6, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outs("abort");
    chk("abort_writes", wadr.size(), 1);
    chk("abort_adr", wadr.size() > 0 ? wadr[0] : 32'hX, 0);
    @(negedge clk);
    rst_n = 1'b1;
    gen(4);
    run_load(1, 4, 0);
    wait_done();
    check_writes(1);
    // stray start during collection
    gen(8);
    run_load(2, 8, 3);
    wait_done();
    check_writes(2);
    repeat (10) @(negedge clk);
    chk("ignored_start_writes", wadr.size(), 2);
    chk("ignored_start_done", bus.done, 1);
    // random loads
    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(1, 8);
      gen(4 * n);
      run_load(n, 4 * n, $urandom_range(0, 2));
      wait_done();
      check_writes(n);
      chk("rand_err", bus.err, 0);
    end
    // largest legal count
    gen(256);
    run_load(64, 256, 0);
    wait_done();
    check_writes(64);
    chk("max_err", bus.err, 0);
    chk("protocol_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
